// File: rtl/memory_game_ctrl.sv
// Memory card game sequencer: two-pick flip, pair compare, timed mismatch display, move/pair counting.
// Optional move limit with game_lost is enabled by defining MOVE_LIMIT_EN.
module memory_game_ctrl #(
  parameter int NUM_CARDS   = 16,
  parameter int POS_W       = 6,
  parameter int ID_W        = 5,
  parameter int SHOW_CYCLES = 25000000,
  parameter int MOVE_W      = 10,
  parameter int MAX_MOVES   = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      new_game,
  input  logic [NUM_CARDS*ID_W-1:0] layout,
  input  logic                      sel_valid,
  input  logic [POS_W-1:0]          sel_pos,
  output logic                      sel_ready,
  output logic [NUM_CARDS-1:0]      flipped,
  output logic [NUM_CARDS-1:0]      removed,
  output logic                      unselect_all,
  output logic                      match_pulse,
  output logic                      mismatch_pulse,
  output logic [POS_W-1:0]          pairs_found,
  output logic [MOVE_W-1:0]         moves,
  output logic                      game_over,
  output logic                      game_lost
);

`ifdef MOVE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  typedef enum logic [2:0] {PICK1, PICK2, COMPARE, SHOW, DONE} state_t;
  state_t state, stateNext;

  // First/second picks are held as one-hot masks so no position index needs width fitting.
  logic [NUM_CARDS-1:0] firstMask, secondMask, firstNext, secondNext;
  logic [NUM_CARDS-1:0] flippedNext, removedNext, selMask;
  logic [TMR_W-1:0]     timer, timerNext;
  logic [ID_W-1:0]      idFirst, idSecond;
  logic [POS_W-1:0]     pairsNext, pairsInc;
  logic [MOVE_W-1:0]    movesNext;
  logic                 selAccept, limitHit, lost;
  logic                 unselNext, matchNext, mismatchNext, overNext, lostNext;

  assign selMask   = {{(NUM_CARDS-1){1'b0}}, 1'b1} << sel_pos;
  assign selAccept = sel_valid && sel_ready && (32'(sel_pos) < 32'(NUM_CARDS))
                     && !(|(selMask & (flipped | removed)));
  assign limitHit  = LIMIT_EN && (32'(moves) >= 32'(MAX_MOVES));
  assign pairsInc  = pairs_found + POS_W'(1);

  always_comb begin
    idFirst  = '0;
    idSecond = '0;
    for (int unsigned p = 0; p < NUM_CARDS; p++) begin
      if (firstMask[p])  idFirst  = layout[p*ID_W +: ID_W];
      if (secondMask[p]) idSecond = layout[p*ID_W +: ID_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state <= PICK1;
    else if (new_game) state <= PICK1;
    else               state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    flippedNext  = flipped;
    removedNext  = removed;
    firstNext    = firstMask;
    secondNext   = secondMask;
    timerNext    = timer;
    pairsNext    = pairs_found;
    movesNext    = moves;
    overNext     = game_over;
    lostNext     = lost;
    unselNext    = 1'b0;
    matchNext    = 1'b0;
    mismatchNext = 1'b0;
    case (state)
      PICK1: if (selAccept) begin
        flippedNext = flipped | selMask;
        firstNext   = selMask;
        stateNext   = PICK2;
      end
      PICK2: if (selAccept) begin
        flippedNext = flipped | selMask;
        secondNext  = selMask;
        movesNext   = (moves == '1) ? moves : moves + MOVE_W'(1);
        stateNext   = COMPARE;
      end
      COMPARE: begin
        if (idFirst == idSecond) begin
          removedNext = removed | firstMask | secondMask;
          flippedNext = flipped & ~(firstMask | secondMask);
          matchNext   = 1'b1;
          pairsNext   = pairsInc;
          if (32'(pairsInc) == 32'(NUM_CARDS / 2)) begin
            overNext  = 1'b1;
            stateNext = DONE;
          end else if (limitHit) begin
            lostNext  = 1'b1;
            stateNext = DONE;
          end else begin
            stateNext = PICK1;
          end
        end else begin
          mismatchNext = 1'b1;
          if (limitHit) begin
            // Out of moves: skip the display and turn the pair back immediately.
            flippedNext = '0;
            unselNext   = 1'b1;
            lostNext    = 1'b1;
            stateNext   = DONE;
          end else begin
            timerNext = TMR_W'(SHOW_CYCLES - 1);
            stateNext = SHOW;
          end
        end
      end
      SHOW: begin
        if (timer == '0) begin
          flippedNext = '0;
          unselNext   = 1'b1;
          stateNext   = PICK1;
        end else begin
          timerNext = timer - TMR_W'(1);
        end
      end
      DONE:    stateNext = DONE;
      default: stateNext = PICK1;
    endcase
  end

  always_comb begin
    sel_ready = (state == PICK1) || (state == PICK2);
    game_lost = LIMIT_EN && lost;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || new_game) begin
      flipped        <= '0;
      removed        <= '0;
      firstMask      <= '0;
      secondMask     <= '0;
      timer          <= '0;
      pairs_found    <= '0;
      moves          <= '0;
      game_over      <= 1'b0;
      lost           <= 1'b0;
      unselect_all   <= 1'b0;
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
    end else begin
      flipped        <= flippedNext;
      removed        <= removedNext;
      firstMask      <= firstNext;
      secondMask     <= secondNext;
      timer          <= timerNext;
      pairs_found    <= pairsNext;
      moves          <= movesNext;
      game_over      <= overNext;
      lost           <= lostNext;
      unselect_all   <= unselNext;
      match_pulse    <= matchNext;
      mismatch_pulse <= mismatchNext;
    end
  end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl: directed scenarios plus randomized games against a
// board-level reference model (card arrays, pick list, counters).
module tb_memory_game_ctrl;
  localparam int NC   = 4;
  localparam int PW   = 3;
  localparam int IW   = 2;
  localparam int SC   = 3;
  localparam int MW   = 4;
  localparam int MAXM = 2;
  localparam int MOVE_SAT = (1 << MW) - 1;
  localparam int ALLW = 2*NC + 3 + PW + MW + 2;

  logic clk = 1'b0, rst_n = 1'b0, new_game = 1'b0, sel_valid = 1'b0;
  logic [PW-1:0]    sel_pos = '0;
  logic [NC*IW-1:0] layout = '0;
  logic             sel_ready, unselect_all, match_pulse, mismatch_pulse, game_over, game_lost;
  logic [NC-1:0]    flipped, removed;
  logic [PW-1:0]    pairs_found;
  logic [MW-1:0]    moves;
  logic [ALLW-1:0]  allOut;

  int checks = 0, errors = 0;

  // Reference model: card ids, face-up/removed sets, pending first pick, counters.
  int ids[NC];
  logic [NC-1:0] mFlip, mRem;
  int mPairs, mMoves, mFirst;
  bit mOver, mLost;

  always #5 clk = ~clk;

  assign allOut = {flipped, removed, unselect_all, match_pulse, mismatch_pulse,
                   pairs_found, moves, game_over, game_lost};

  memory_game_ctrl #(
    .NUM_CARDS(NC), .POS_W(PW), .ID_W(IW), .SHOW_CYCLES(SC), .MOVE_W(MW), .MAX_MOVES(MAXM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .layout(layout),
    .sel_valid(sel_valid), .sel_pos(sel_pos), .sel_ready(sel_ready),
    .flipped(flipped), .removed(removed), .unselect_all(unselect_all),
    .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse),
    .pairs_found(pairs_found), .moves(moves), .game_over(game_over), .game_lost(game_lost)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic loadLayout();
    for (int p = 0; p < NC; p++) layout[p*IW +: IW] = IW'(ids[p]);
  endtask

  task automatic modelClear();
    mFlip = '0; mRem = '0; mPairs = 0; mMoves = 0; mFirst = -1; mOver = 0; mLost = 0;
  endtask

  function automatic bit limitReached();
`ifdef MOVE_LIMIT_EN
    return mMoves >= MAXM;
`else
    return 1'b0;
`endif
  endfunction

  task automatic newGame();
    new_game = 1'b1;
    cycle();
    new_game = 1'b0;
    modelClear();
    checks++; if (allOut !== '0) begin errors++; $display("FAIL newgame_clear: got %h expected 0", allOut); end
    checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL newgame_ready: got %b expected 1", sel_ready); end
  endtask

  // One selection pulse, then the expected consequence (match / full mismatch display) per the model.
  task automatic pickCard(input int pos);
    bit acc;
    int second;
    acc = !mOver && !mLost && pos < NC && !mRem[pos] && !mFlip[pos];
    sel_valid = 1'b1; sel_pos = PW'(pos);
    cycle();
    sel_valid = 1'b0;
    if (!acc) begin
      checks++; if (flipped !== mFlip || removed !== mRem || moves !== MW'(mMoves)) begin errors++;
        $display("FAIL reject_p%0d: got f=%b r=%b m=%0d expected f=%b r=%b m=%0d", pos, flipped, removed, moves, mFlip, mRem, mMoves); end
      checks++; if (sel_ready !== !(mOver || mLost)) begin errors++; $display("FAIL reject_ready: got %b expected %b", sel_ready, !(mOver || mLost)); end
      return;
    end
    mFlip[pos] = 1'b1;
    if (mFirst < 0) begin
      mFirst = pos;
      checks++; if (flipped !== mFlip || sel_ready !== 1'b1) begin errors++;
        $display("FAIL pick1_p%0d: got f=%b rdy=%b expected f=%b rdy=1", pos, flipped, sel_ready, mFlip); end
      return;
    end
    second = pos;
    if (mMoves < MOVE_SAT) mMoves++;
    checks++; if (flipped !== mFlip || moves !== MW'(mMoves) || sel_ready !== 1'b0) begin errors++;
      $display("FAIL pick2_p%0d: got f=%b m=%0d rdy=%b expected f=%b m=%0d rdy=0", pos, flipped, moves, sel_ready, mFlip, mMoves); end
    cycle();
    if (ids[mFirst] == ids[second]) begin
      mRem[mFirst] = 1'b1; mRem[second] = 1'b1; mFlip = '0; mPairs++;
      if (mPairs == NC/2) mOver = 1'b1;
      else if (limitReached()) mLost = 1'b1;
      checks++; if ({match_pulse, mismatch_pulse, unselect_all} !== 3'b100) begin errors++;
        $display("FAIL match_pulses: got %b expected 100", {match_pulse, mismatch_pulse, unselect_all}); end
      checks++; if (removed !== mRem || flipped !== mFlip || pairs_found !== PW'(mPairs)) begin errors++;
        $display("FAIL match_state: got r=%b f=%b p=%0d expected r=%b f=%b p=%0d", removed, flipped, pairs_found, mRem, mFlip, mPairs); end
      checks++; if (game_over !== mOver || game_lost !== mLost || sel_ready !== !(mOver || mLost)) begin errors++;
        $display("FAIL match_end: got ov=%b lo=%b rdy=%b expected ov=%b lo=%b", game_over, game_lost, sel_ready, mOver, mLost); end
    end else if (limitReached()) begin
      mFlip = '0; mLost = 1'b1;
      checks++; if ({mismatch_pulse, unselect_all, game_lost, game_over, sel_ready} !== 5'b11100 || flipped !== '0) begin errors++;
        $display("FAIL limit_mismatch: got mm/un/lo/ov/rdy=%b f=%b expected 11100 f=0000",
                 {mismatch_pulse, unselect_all, game_lost, game_over, sel_ready}, flipped); end
    end else begin
      checks++; if ({match_pulse, mismatch_pulse, unselect_all} !== 3'b010 || flipped !== mFlip) begin errors++;
        $display("FAIL mismatch: got pulses=%b f=%b expected 010 f=%b", {match_pulse, mismatch_pulse, unselect_all}, flipped, mFlip); end
      for (int k = 1; k < SC; k++) begin
        sel_valid = 1'(($urandom & 1)); sel_pos = PW'($urandom_range(0, (1 << PW) - 1));
        cycle();
        checks++; if (flipped !== mFlip || {unselect_all, mismatch_pulse, sel_ready} !== 3'b000) begin errors++;
          $display("FAIL show_hold_%0d: got f=%b un/mm/rdy=%b expected f=%b 000", k, flipped, {unselect_all, mismatch_pulse, sel_ready}, mFlip); end
      end
      cycle();
      sel_valid = 1'b0;
      mFlip = '0;
      checks++; if (flipped !== '0 || unselect_all !== 1'b1 || sel_ready !== 1'b1) begin errors++;
        $display("FAIL show_end: got f=%b un=%b rdy=%b expected f=0000 un=1 rdy=1", flipped, unselect_all, sel_ready); end
    end
    mFirst = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ids = '{0, 1, 0, 1};
    loadLayout();
    #12;
    checks++; if (allOut !== '0 || sel_ready !== 1'b1) begin errors++; $display("FAIL reset: got %h rdy=%b expected 0 rdy=1", allOut, sel_ready); end
    rst_n = 1'b1;
    modelClear();
    cycle();
    checks++; if (allOut !== '0) begin errors++; $display("FAIL post_reset: got %h expected 0", allOut); end
  endtask

  task automatic test_match();
    newGame();
    pickCard(0); pickCard(2);
    checks++; if (removed !== 4'b0101 || flipped !== 4'b0000 || pairs_found !== 3'd1 || moves !== 4'd1) begin errors++;
      $display("FAIL match_board: got r=%b f=%b p=%0d m=%0d expected r=0101 f=0000 p=1 m=1", removed, flipped, pairs_found, moves); end
  endtask

  task automatic test_reject_and_finish();
    pickCard(0); pickCard(1); pickCard(1); pickCard(5);
    checks++; if (flipped !== 4'b0010 || sel_ready !== 1'b1 || moves !== 4'd1) begin errors++;
      $display("FAIL reject_board: got f=%b rdy=%b m=%0d expected f=0010 rdy=1 m=1", flipped, sel_ready, moves); end
    pickCard(3);
    checks++; if (pairs_found !== 3'd2 || game_over !== 1'b1 || game_lost !== 1'b0 || removed !== 4'b1111) begin errors++;
      $display("FAIL game_over: got p=%0d ov=%b lo=%b r=%b expected p=2 ov=1 lo=0 r=1111", pairs_found, game_over, game_lost, removed); end
    pickCard(1); pickCard(6);
    checks++; if (sel_ready !== 1'b0 || flipped !== 4'b0000) begin errors++;
      $display("FAIL done_ignore: got rdy=%b f=%b expected rdy=0 f=0000", sel_ready, flipped); end
    newGame();
  endtask

  task automatic test_mismatch();
    newGame();
    pickCard(1); pickCard(2);
    checks++; if (moves !== 4'd1 || flipped !== 4'b0000 || removed !== 4'b0000 || sel_ready !== 1'b1) begin errors++;
      $display("FAIL mismatch_after: got m=%0d f=%b r=%b rdy=%b expected m=1 f=0000 r=0000 rdy=1", moves, flipped, removed, sel_ready); end
  endtask

  task automatic enterShow();
    newGame();
    sel_valid = 1'b1; sel_pos = 3'd1; cycle();
    sel_pos = 3'd2; cycle();
    sel_valid = 1'b0; cycle();
    cycle();
    checks++; if (flipped !== 4'b0110 || sel_ready !== 1'b0) begin errors++;
      $display("FAIL in_show: got f=%b rdy=%b expected f=0110 rdy=0", flipped, sel_ready); end
  endtask

  task automatic test_reset_in_show();
    enterShow();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (allOut !== '0 || sel_ready !== 1'b1) begin errors++; $display("FAIL async_reset: got %h rdy=%b expected 0 rdy=1", allOut, sel_ready); end
    #2 rst_n = 1'b1;
    modelClear();
    for (int k = 0; k < SC + 3; k++) begin
      cycle();
      checks++; if (unselect_all !== 1'b0 || flipped !== '0) begin errors++;
        $display("FAIL reset_no_unsel_%0d: got un=%b f=%b expected un=0 f=0000", k, unselect_all, flipped); end
    end
  endtask

  task automatic test_new_game_in_show();
    enterShow();
    new_game = 1'b1; sel_valid = 1'b1; sel_pos = 3'd0;
    cycle();
    new_game = 1'b0; sel_valid = 1'b0;
    modelClear();
    checks++; if (allOut !== '0 || sel_ready !== 1'b1) begin errors++; $display("FAIL newgame_priority: got %h rdy=%b expected 0 rdy=1", allOut, sel_ready); end
    for (int k = 0; k < SC + 2; k++) begin
      cycle();
      checks++; if (unselect_all !== 1'b0) begin errors++; $display("FAIL newgame_no_unsel_%0d: got %b expected 0", k, unselect_all); end
    end
    pickCard(0); pickCard(2);
  endtask

  task automatic test_saturation();
    newGame();
    for (int i = 0; i < MOVE_SAT + 2; i++) begin
      pickCard(0); pickCard(1);
    end
    checks++; if (moves !== MW'(mMoves) || game_lost !== mLost) begin errors++;
      $display("FAIL saturation: got m=%0d lo=%b expected m=%0d lo=%b", moves, game_lost, mMoves, mLost); end
  endtask

`ifdef MOVE_LIMIT_EN
  task automatic test_move_limit();
    newGame();
    pickCard(1); pickCard(2);
    pickCard(0); pickCard(1);
    pickCard(3);
    checks++; if (game_lost !== 1'b1 || game_over !== 1'b0 || flipped !== 4'b0000 || sel_ready !== 1'b0) begin errors++;
      $display("FAIL move_limit: got lo=%b ov=%b f=%b rdy=%b expected lo=1 ov=0 f=0000 rdy=0", game_lost, game_over, flipped, sel_ready); end
  endtask
`endif

  task automatic test_random_games();
    int vals[NC];
    int cand[$];
    int a, b, j, t, pos;
    for (int g = 0; g < 25; g++) begin
      a = $urandom_range(0, 3);
      b = (a + 1 + $urandom_range(0, 2)) % 4;
      vals = '{a, a, b, b};
      for (int i = NC - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = vals[i]; vals[i] = vals[j]; vals[j] = t;
      end
      ids = vals;
      loadLayout();
      newGame();
      for (int s = 0; s < 30 && !(mOver || mLost); s++) begin
        repeat ($urandom_range(0, 2)) cycle();
        cand.delete();
        for (int p = 0; p < NC; p++) if (!mRem[p] && !mFlip[p]) cand.push_back(p);
        if (($urandom % 3) == 0 || cand.size() == 0) pos = $urandom_range(0, (1 << PW) - 1);
        else pos = cand[$urandom_range(0, cand.size() - 1)];
        pickCard(pos);
      end
      checks++; if (game_over !== mOver || pairs_found !== PW'(mPairs) || moves !== MW'(mMoves)) begin errors++;
        $display("FAIL random_game_%0d: got ov=%b p=%0d m=%0d expected ov=%b p=%0d m=%0d", g, game_over, pairs_found, moves, mOver, mPairs, mMoves); end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_reject_and_finish();
    test_mismatch();
    test_reset_in_show();
    test_new_game_in_show();
    ids = '{0, 1, 0, 1};
    loadLayout();
    test_saturation();
`ifdef MOVE_LIMIT_EN
    test_move_limit();
`endif
    test_random_games();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_game_ctrl.md
Name: memory_game_ctrl

Overview:
- Sequencer for the memory card game: accepts player card selections, manages first/second flip, compares the pair and removes matched cards.
- Holds a mismatched pair face-up for a fixed display time, then flips both back.
- Counts moves and found pairs, and flags game over.
- Sits between the input decoder (selection pulses) and the card display / per-pair card logic, which consumes the flipped and removed masks plus the unselect_all pulse.

Parameters:
- NUM_CARDS, 16, number of board positions; must be even, 4..64.
- POS_W, 6, width of position index; 2^POS_W >= NUM_CARDS.
- ID_W, 5, width of pair identifier; 2^ID_W >= NUM_CARDS/2.
- SHOW_CYCLES, 25000000, clock cycles a mismatched pair stays visible; >= 1.
- MOVE_W, 10, width of move counter.
- MAX_MOVES, 40, move limit, used only with MOVE_LIMIT_EN.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- new_game  in  1  synchronous one-cycle restart pulse.
- layout  in  NUM_CARDS*ID_W  pair id of each position, position p at bits [p*ID_W +: ID_W]; must stay stable during a game.
- sel_valid  in  1  selection request.
- sel_pos  in  POS_W  selected position.
- sel_ready  out  1  controller can accept a selection.
- flipped  out  NUM_CARDS  face-up, not-yet-removed cards.
- removed  out  NUM_CARDS  matched cards (out of game).
- unselect_all  out  1  one-cycle pulse when face-up cards are turned back.
- match_pulse  out  1  one-cycle pulse on a pair match.
- mismatch_pulse  out  1  one-cycle pulse on a mismatch.
- pairs_found  out  POS_W  matched pair count.
- moves  out  MOVE_W  completed second picks, saturating at all-ones.
- game_over  out  1  all pairs found, level.
- game_lost  out  1  move limit reached, level; constant 0 without MOVE_LIMIT_EN.

Behaviour:
- Reset (rst_n low, async) and new_game (sync) clear all outputs and counters, state to PICK1. new_game has priority over any other event in the same cycle, including an in-flight SHOW.
- States: PICK1, PICK2, COMPARE, SHOW, DONE.
- sel_ready = 1 in PICK1/PICK2, else 0.
- A selection is accepted only when all hold:
  - sel_valid and sel_ready;
  - sel_pos < NUM_CARDS;
  - removed[sel_pos] = 0;
  - flipped[sel_pos] = 0.
- Rejected selections are ignored with no state or counter change; re-selecting the first card is therefore ignored.
- PICK1: accept at cycle T: flipped[sel_pos] set at T+1, pos stored as first, state PICK2.
- PICK2: accept at T: flipped bit set at T+1, pos stored as second, moves incremented at T+1, state COMPARE.
- COMPARE (1 cycle, at T+1): compare layout ids of first and second.
  - Equal: at T+2 both removed bits set, both flipped bits cleared, match_pulse = 1, pairs_found incremented. Next state DONE if pairs_found becomes NUM_CARDS/2, else PICK1.
  - Not equal: at T+2 mismatch_pulse = 1, timer loaded with SHOW_CYCLES-1, state SHOW.
- SHOW: timer decrements each cycle. The cycle after the timer reads 0, flipped is cleared, unselect_all = 1 for one cycle, state PICK1. Flipped cards stay visible exactly SHOW_CYCLES cycles after mismatch_pulse.
- DONE: game_over = 1; ignores selections until new_game or reset.
- Removed cards never return to flipped. Flipped and removed are disjoint at all times.
- All outputs are registered; there is no combinational path from sel_* to outputs except sel_ready (state-only).

Optional Feature:
- MOVE_LIMIT_EN defined:
  - When moves reaches MAX_MOVES after a COMPARE that did not finish the game, state goes to DONE and game_lost = 1. The mismatch SHOW is skipped, flipped is cleared, and unselect_all pulses in the same cycle as mismatch_pulse.
  - A match that finishes the game on the limit move gives game_over = 1, game_lost = 0.
- Not defined: no limit; game_lost tied 0; moves saturates.

Test Plan:
- NUM_CARDS=4, SHOW_CYCLES=3, layout ids {p0=0,p1=1,p2=0,p3=1}. Select 0 then 2 -> match_pulse, removed=0101, flipped=0000, pairs_found=1, moves=1.
- Select 1 then 2 -> mismatch_pulse; flipped=0110 held exactly 3 cycles, then unselect_all pulse, flipped=0000, moves=1, sel_ready back to 1.
- After the first scenario, select 0 (removed), select 1 twice, select pos 5 -> only one flip of p1 accepted, flipped=0010, state PICK2.
- Full game 0/2 then 1/3 -> pairs_found=2, game_over=1, further sel_valid ignored; new_game -> all cleared, sel_ready=1.
- Assert rst_n low during SHOW mid-count -> all outputs 0 immediately (async), no unselect_all pulse after release.
- With MOVE_LIMIT_EN, MAX_MOVES=2: two mismatches -> after the second, game_lost=1, game_over=0, flipped=0000, selections ignored.
